// File: rtl/divisor_pkg.sv
// Shared types, defaults and helpers for the multi-channel frequency divider.
package divisor_pkg;

  localparam int DEFAULT_WIDTH           = 17;
  localparam int DEFAULT_DIV_100MHZ_1KHZ = 49_999;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  // Channel-select width; never zero, so a single-channel build still has a port.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/divisor_canal.sv
// One divider channel: counter, active/shadow divisor pair, registered clk_out/tick/pending.
// Optional phase-align input under DIVISOR_PHASE_SYNC_EN.
module divisor_canal
  import divisor_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEFAULT_DIV = DEFAULT_DIV_100MHZ_1KHZ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
`ifdef DIVISOR_PHASE_SYNC_EN
  input  logic             sync,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(DEFAULT_DIV);

  ch_state_t        state;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] active_reg, active_next;
  logic [WIDTH-1:0] shadow_reg, shadow_next;
  logic             clk_reg, clk_next;
  logic             tick_reg, tick_next;
  logic             pending_reg, pending_next;
  logic             wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      active_reg  <= DEFAULT_VAL;
      shadow_reg  <= DEFAULT_VAL;
      clk_reg     <= 1'b0;
      tick_reg    <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      active_reg  <= active_next;
      shadow_reg  <= shadow_next;
      clk_reg     <= clk_next;
      tick_reg    <= tick_next;
      pending_reg <= pending_next;
    end
  end

  always_comb begin
    state        = en ? CH_RUN : CH_IDLE;
    wrap         = (cnt_reg == active_reg);
    cnt_next     = cnt_reg;
    active_next  = active_reg;
    shadow_next  = shadow_reg;
    clk_next     = clk_reg;
    tick_next    = tick_reg;
    pending_next = pending_reg;

    case (state)
      CH_IDLE: begin
        cnt_next  = '0;
        clk_next  = 1'b0;
        tick_next = 1'b0;
        // A stopped channel has no period to protect, so writes land immediately.
        if (wr) begin
          shadow_next  = wr_div;
          active_next  = wr_div;
          pending_next = 1'b0;
        end else if (pending_reg) begin
          active_next  = shadow_reg;
          pending_next = 1'b0;
        end
      end

      CH_RUN: begin
`ifdef DIVISOR_PHASE_SYNC_EN
        if (sync) begin
          cnt_next     = '0;
          clk_next     = 1'b0;
          tick_next    = 1'b0;
          active_next  = shadow_reg;
          pending_next = 1'b0;
        end else
`endif
        if (wrap) begin
          cnt_next     = '0;
          clk_next     = ~clk_reg;
          tick_next    = 1'b1;
          active_next  = shadow_reg;
          pending_next = 1'b0;
        end else begin
          cnt_next  = cnt_reg + WIDTH'(1);
          tick_next = 1'b0;
        end
        // A write coinciding with a wrap still waits for the following wrap.
        if (wr) begin
          shadow_next  = wr_div;
          pending_next = 1'b1;
        end
      end

      default: ;
    endcase
  end

  assign clk_out = clk_reg;
  assign tick    = tick_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/divisor_frecuencia_multi.sv
// Multi-channel programmable frequency divider: write decode and channel array.
// Build with DIVISOR_PHASE_SYNC_EN to add the sync phase-align input.
module divisor_frecuencia_multi
  import divisor_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEFAULT_DIV = DEFAULT_DIV_100MHZ_1KHZ
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNELS-1:0]             en,
  input  logic                            wr_en,
  input  logic [ch_width(CHANNELS)-1:0]   wr_ch,
  input  logic [WIDTH-1:0]                wr_div,
`ifdef DIVISOR_PHASE_SYNC_EN
  input  logic                            sync,
`endif
  output logic [CHANNELS-1:0]             clk_out,
  output logic [CHANNELS-1:0]             tick,
  output logic [CHANNELS-1:0]             pending
);

  localparam int CH_W = ch_width(CHANNELS);

  logic [CHANNELS-1:0] wr_sel;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      // Channel numbers at or above CHANNELS match no slot, so such writes vanish.
      assign wr_sel[gi] = wr_en && (wr_ch == CH_W'(gi));

      divisor_canal #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_canal (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en[gi]),
        .wr      (wr_sel[gi]),
        .wr_div  (wr_div),
`ifdef DIVISOR_PHASE_SYNC_EN
        .sync    (sync),
`endif
        .clk_out (clk_out[gi]),
        .tick    (tick[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_divisor_frecuencia_multi.sv
// Self-checking bench: countdown/queue reference model compared every cycle, plus literal timing pins.
module tb_divisor_frecuencia_multi;
  localparam int NCH = 5;
  localparam int W   = 17;
  localparam int DEF = 49_999;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] en = '1;
  logic           wr_en = 1'b0;
  logic [CW-1:0]  wr_ch = '0;
  logic [W-1:0]   wr_div = '0;
  logic [NCH-1:0] clk_out, tick, pending;
`ifdef DIVISOR_PHASE_SYNC_EN
  logic           sync = 1'b0;
`endif

  always #5 clk = ~clk;

  divisor_frecuencia_multi #(
    .CHANNELS    (NCH),
    .WIDTH       (W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
`ifdef DIVISOR_PHASE_SYNC_EN
    .sync    (sync),
`endif
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_vec(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Model: cycles left before the next wrap, divisor in force, queued divisor (-1 = none).
  int  m_per[NCH];
  int  m_left[NCH];
  int  m_q[NCH];
  bit  m_clk[NCH];
  bit  m_tick[NCH];
  bit  m_valid = 1'b0;
  logic [NCH-1:0] exp_clk, exp_tick, exp_pend;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_per[c] = DEF; m_left[c] = DEF; m_q[c] = -1; m_clk[c] = 0; m_tick[c] = 0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int c = 0; c < NCH; c++) begin
        automatic bit hit = wr_en && (int'(wr_ch) == c);
        if (!en[c]) begin
          if (hit) begin
            m_per[c] = int'(wr_div); m_q[c] = -1;
          end else if (m_q[c] >= 0) begin
            m_per[c] = m_q[c]; m_q[c] = -1;
          end
          m_left[c] = m_per[c]; m_clk[c] = 0; m_tick[c] = 0;
        end else begin
          if (m_left[c] == 0) begin
            if (m_q[c] >= 0) m_per[c] = m_q[c];
            m_q[c] = -1; m_left[c] = m_per[c]; m_clk[c] = !m_clk[c]; m_tick[c] = 1;
          end else begin
            m_left[c]--; m_tick[c] = 0;
          end
          if (hit) m_q[c] = int'(wr_div);
        end
      end
    end
    if (m_valid) begin
      for (int c = 0; c < NCH; c++) begin
        exp_clk[c]  = m_clk[c];
        exp_tick[c] = m_tick[c];
        exp_pend[c] = (m_q[c] >= 0);
      end
      check_vec("model_clk_out", clk_out, exp_clk);
      check_vec("model_tick", tick, exp_tick);
      check_vec("model_pending", pending, exp_pend);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_write(input int ch, input int d);
    wr_en  = 1'b1;
    wr_ch  = CW'(ch);
    wr_div = W'(d);
    $display("write ch=%0d div=%0d en=%b t=%0t", ch, d, en, $time);
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!tick[ch] && n < limit);
    if (!tick[ch]) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout ch%0d: got no tick, expected one within %0d cycles", ch, limit);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish before 5 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, first_hit, second_hit, toggles, prev;

    // Reset held with all channels enabled.
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check_vec("reset_outputs", clk_out | tick | pending, '0);
    end
    rst_n = 1'b1;
    wait_tick(0, 60_000, n);
    check_int("first_tick_ch0", n, 50_000);

    // Basic divide on channel 1 with D=3.
    en = '0;
    cyc(1);
    do_write(1, 3);
    en[1] = 1'b1;
    wait_tick(1, 20, n);
    check_int("first_tick_d3", n, 4);
    wait_tick(1, 20, n);
    check_int("tick_gap_d3", n, 4);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      acc += int'(clk_out[1]);
    end
    check_int("clk_out_duty_d3", acc, 4);

    // Run-time change to D=1 written while cnt=1.
    wait_tick(1, 20, n);
    cyc(1);
    do_write(1, 1);
    check_int("pending_after_write", int'(pending[1]), 1);
    wait_tick(1, 20, n);
    check_int("wrap_after_write", n, 2);
    check_int("pending_cleared", int'(pending[1]), 0);
    wait_tick(1, 20, n);
    check_int("tick_gap_d1", n, 2);

    // Write landing exactly on the wrap edge.
    en[1] = 1'b0;
    cyc(1);
    do_write(1, 3);
    en[1] = 1'b1;
    wait_tick(1, 20, n);
    cyc(3);
    do_write(1, 1);
    check_int("wrap_edge_tick", int'(tick[1]), 1);
    check_int("wrap_edge_pending", int'(pending[1]), 1);
    wait_tick(1, 20, n);
    check_int("old_period_kept", n, 4);
    check_int("pending_cleared_late", int'(pending[1]), 0);
    wait_tick(1, 20, n);
    check_int("new_period_d1", n, 2);

    // Divisor 0: tick stays high, clk_out toggles every cycle.
    en = '0;
    cyc(1);
    do_write(2, 0);
    en[2] = 1'b1;
    cyc(1);
    prev = int'(clk_out[2]);
    acc = 0;
    toggles = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      acc += int'(tick[2]);
      if (int'(clk_out[2]) != prev) toggles++;
      prev = int'(clk_out[2]);
    end
    check_int("d0_tick_high", acc, 6);
    check_int("d0_toggles", toggles, 6);

    // Out-of-range channel numbers change nothing.
    en[1] = 1'b1;
    do_write(5, 7);
    do_write(7, 2);
    check_vec("oor_pending", pending, '0);
    wait_tick(1, 20, n);
    wait_tick(1, 20, n);
    check_int("oor_gap_ch1", n, 2);

    // Dropping en mid-count.
    en = '0;
    cyc(1);
    do_write(3, 9);
    en[3] = 1'b1;
    cyc(13);
    check_int("ch3_clk_high", int'(clk_out[3]), 1);
    en[3] = 1'b0;
    cyc(1);
    check_int("ch3_drop_clk", int'(clk_out[3]), 0);
    check_int("ch3_drop_tick", int'(tick[3]), 0);

    // Independence: D=0..3 enabled together, ticks coincide every 12 cycles.
    for (int c = 0; c < 4; c++) do_write(c, c);
    en = 5'b01111;
    first_hit = 0;
    second_hit = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      if (&tick[3:0]) begin
        if (first_hit == 0) first_hit = k;
        else if (second_hit == 0) second_hit = k;
      end
    end
    check_int("coincide_first", first_hit, 12);
    check_int("coincide_second", second_hit, 24);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
      if ($urandom_range(0, 4) == 0) do_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      else cyc(1);
    end

    // Reset asserted mid-operation.
    en = '1;
    rst_n = 1'b0;
    cyc(1);
    check_vec("midreset_outputs", clk_out | tick | pending, '0);
    rst_n = 1'b1;
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
